multi_cycle_control_unit: RTL and testbench

//  Moore/Mealy FSM that sequences the 16-bit multi-cycle datapath: fetch into the instruction

---
 rtl/multi_cycle_control_unit_pkg.sv | 64 ++++++
 rtl/multi_cycle_control_unit_mem_wait_timer.sv | 42 ++++
 rtl/multi_cycle_control_unit.sv | 264 ++++++++++++++++++++++++++
 tb/tb_multi_cycle_control_unit.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_control_unit_pkg.sv
// ---------------------------------------------------------------------------
// multi_cycle_control_unit_pkg
// Shared types and constants for the multi-cycle control unit: the FSM state
// encoding, IR opcode values, ALU function codes, and the ALUSrcB / PCSrc mux
// encodings. Also holds small state-classification helpers.
// ---------------------------------------------------------------------------
package multi_cycle_control_unit_pkg;

    // The encoding is visible on Output_CU_State, so every value is fixed.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_DISPATCH = 4'd3,
        ST_EXEC_R   = 4'd4,
        ST_EXEC_I   = 4'd5,
        ST_ALU_WB   = 4'd6,
        ST_MEM_ADDR = 4'd7,
        ST_MEM_RD   = 4'd8,
        ST_MEM_WB   = 4'd9,
        ST_MEM_WR   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_HALT     = 4'd13,
        ST_ERROR    = 4'd14
    } cu_state_e;

    // IR opcode field values
    localparam logic [2:0] OP_R    = 3'd0;
    localparam logic [2:0] OP_I    = 3'd1;
    localparam logic [2:0] OP_LD   = 3'd2;
    localparam logic [2:0] OP_ST   = 3'd3;
    localparam logic [2:0] OP_BR   = 3'd4;
    localparam logic [2:0] OP_J    = 3'd5;
    localparam logic [2:0] OP_LUI  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    // ALU function codes the control unit forces itself
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_PASSB = 4'd15;

    // ALU operand-B mux
    localparam logic [1:0] SRCB_REGB = 2'd0;
    localparam logic [1:0] SRCB_TWO  = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;

    // PC source mux
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_IMM    = 2'd2;

    // States that hold a memory request open until MemReady.
    function automatic logic is_mem_wait_state(input cu_state_e s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

    // States whose exit to FETCH retires an instruction.
    function automatic logic is_completing_state(input cu_state_e s);
        return (s == ST_ALU_WB) || (s == ST_MEM_WB) || (s == ST_MEM_WR) ||
               (s == ST_BRANCH) || (s == ST_JUMP);
    endfunction

endpackage

// File: rtl/multi_cycle_control_unit_mem_wait_timer.sv
// ---------------------------------------------------------------------------
// multi_cycle_control_unit_mem_wait_timer
// Counts the cycles a memory state has spent waiting for MemReady.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : synchronous clear (takes priority over count)
//   count        : advance by one this cycle
//   expired      : this is the MEM_WAIT_MAX-th waiting cycle
// ---------------------------------------------------------------------------
module multi_cycle_control_unit_mem_wait_timer #(
    parameter int MEM_WAIT_MAX = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int W = $clog2(MEM_WAIT_MAX + 1);
    // The counter starts at 0 in the first waiting cycle, so the last
    // permitted waiting cycle is the one where it reads MEM_WAIT_MAX-1.
    localparam logic [W-1:0] LAST = W'(MEM_WAIT_MAX - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] cnt_r;

    assign expired = (cnt_r == LAST);

    // Wait counter: clear wins, saturates once expired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (count && !expired) begin
            cnt_r <= cnt_r + ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// ---------------------------------------------------------------------------
// multi_cycle_control_unit
// FSM sequencing a 16-bit multi-cycle datapath: fetch, decode, dispatch,
// execute, memory access and write-back. Outputs are decoded from the state
// register; IRWrite/PCWrite in FETCH and PCWrite in BRANCH also depend on the
// current MemReady / Zero inputs.
//
// Optional feature macro: CTRL_PERF_CNT_EN adds cycle / instruction counters.
//
// Ports
//   CLK, RST_n           clock, asynchronous active-low reset
//   input_CU_Control     IR control field {func4[6:3], opcode[2:0]}
//   input_CU_Zero        ALU zero flag
//   input_CU_MemReady    memory completes current access this cycle
//   input_CU_Run         start from IDLE / resume from HALT
//   Output_CU_*          datapath enables and mux selects, state, status
//   Output_CU_CycleCnt   (CTRL_PERF_CNT_EN) active cycle count
//   Output_CU_InstrCnt   (CTRL_PERF_CNT_EN) retired instruction count
// ---------------------------------------------------------------------------
module multi_cycle_control_unit
    import multi_cycle_control_unit_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 16
`ifdef CTRL_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic [6:0] input_CU_Control,
    input  logic       input_CU_Zero,
    input  logic       input_CU_MemReady,
    input  logic       input_CU_Run,
    output logic       Output_CU_PCWrite,
    output logic       Output_CU_IRWrite,
    output logic       Output_CU_MemRead,
    output logic       Output_CU_MemWrite,
    output logic       Output_CU_IorD,
    output logic       Output_CU_RegWrite,
    output logic       Output_CU_MemToReg,
    output logic       Output_CU_ALUSrcA,
    output logic [1:0] Output_CU_ALUSrcB,
    output logic [3:0] Output_CU_ALUOp,
    output logic [1:0] Output_CU_PCSrc,
    output logic [3:0] Output_CU_State,
    output logic       Output_CU_Halted,
    output logic       Output_CU_Error
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] Output_CU_CycleCnt,
    output logic [CNT_W-1:0] Output_CU_InstrCnt
`endif
);

    cu_state_e  state_r;
    cu_state_e  state_next_s;
    logic [2:0] opcode_s;
    logic [3:0] func4_s;
    logic       wait_clear_s;
    logic       wait_count_s;
    logic       wait_expired_s;

    assign opcode_s        = input_CU_Control[2:0];
    assign func4_s         = input_CU_Control[6:3];
    assign Output_CU_State = state_r;

    // The timer restarts whenever a wait state is entered or left, and only
    // advances while a request is outstanding without MemReady.
    assign wait_clear_s = !is_mem_wait_state(state_r) || (state_next_s != state_r);
    assign wait_count_s = is_mem_wait_state(state_r) && !input_CU_MemReady;

    multi_cycle_control_unit_mem_wait_timer #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_wait_timer (
        .clk     (CLK),
        .rst_n   (RST_n),
        .clear   (wait_clear_s),
        .count   (wait_count_s),
        .expired (wait_expired_s)
    );

    // State register
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic. In wait states MemReady beats the timeout.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (input_CU_Run) state_next_s = ST_FETCH;
                else              state_next_s = ST_IDLE;
            end
            ST_FETCH: begin
                if (input_CU_MemReady)   state_next_s = ST_DECODE;
                else if (wait_expired_s) state_next_s = ST_ERROR;
                else                     state_next_s = ST_FETCH;
            end
            ST_DECODE: state_next_s = ST_DISPATCH;
            ST_DISPATCH: begin
                case (opcode_s)
                    OP_R:    state_next_s = ST_EXEC_R;
                    OP_I:    state_next_s = ST_EXEC_I;
                    OP_LD:   state_next_s = ST_MEM_ADDR;
                    OP_ST:   state_next_s = ST_MEM_ADDR;
                    OP_BR:   state_next_s = ST_BRANCH;
                    OP_J:    state_next_s = ST_JUMP;
                    OP_LUI:  state_next_s = ST_EXEC_I;
                    OP_HALT: state_next_s = ST_HALT;
                    default: state_next_s = ST_ERROR;
                endcase
            end
            ST_EXEC_R: state_next_s = ST_ALU_WB;
            ST_EXEC_I: state_next_s = ST_ALU_WB;
            ST_ALU_WB: state_next_s = ST_FETCH;
            ST_MEM_ADDR: begin
                if (opcode_s == OP_ST) state_next_s = ST_MEM_WR;
                else                   state_next_s = ST_MEM_RD;
            end
            ST_MEM_RD: begin
                if (input_CU_MemReady)   state_next_s = ST_MEM_WB;
                else if (wait_expired_s) state_next_s = ST_ERROR;
                else                     state_next_s = ST_MEM_RD;
            end
            ST_MEM_WB: state_next_s = ST_FETCH;
            ST_MEM_WR: begin
                if (input_CU_MemReady)   state_next_s = ST_FETCH;
                else if (wait_expired_s) state_next_s = ST_ERROR;
                else                     state_next_s = ST_MEM_WR;
            end
            ST_BRANCH: state_next_s = ST_FETCH;
            ST_JUMP:   state_next_s = ST_FETCH;
            ST_HALT: begin
                if (input_CU_Run) state_next_s = ST_FETCH;
                else              state_next_s = ST_HALT;
            end
            ST_ERROR: state_next_s = ST_ERROR;
            default:  state_next_s = ST_ERROR;
        endcase
    end

    // Output decode. Everything is inactive unless the state asserts it.
    always_comb begin
        Output_CU_PCWrite  = 1'b0;
        Output_CU_IRWrite  = 1'b0;
        Output_CU_MemRead  = 1'b0;
        Output_CU_MemWrite = 1'b0;
        Output_CU_IorD     = 1'b0;
        Output_CU_RegWrite = 1'b0;
        Output_CU_MemToReg = 1'b0;
        Output_CU_ALUSrcA  = 1'b0;
        Output_CU_ALUSrcB  = SRCB_REGB;
        Output_CU_ALUOp    = ALU_ADD;
        Output_CU_PCSrc    = PCSRC_ALU;
        Output_CU_Halted   = 1'b0;
        Output_CU_Error    = 1'b0;
        case (state_r)
            ST_IDLE: Output_CU_Halted = 1'b1;
            ST_FETCH: begin
                // PC+2 is computed while the instruction is read; both
                // registers load only in the cycle memory delivers.
                Output_CU_MemRead = 1'b1;
                Output_CU_IorD    = 1'b0;
                Output_CU_ALUSrcA = 1'b0;
                Output_CU_ALUSrcB = SRCB_TWO;
                Output_CU_ALUOp   = ALU_ADD;
                if (input_CU_MemReady) begin
                    Output_CU_IRWrite = 1'b1;
                    Output_CU_PCWrite = 1'b1;
                end else begin
                    Output_CU_IRWrite = 1'b0;
                    Output_CU_PCWrite = 1'b0;
                end
            end
            ST_DECODE:   Output_CU_Halted = 1'b0;
            ST_DISPATCH: Output_CU_Halted = 1'b0;
            ST_EXEC_R: begin
                Output_CU_ALUSrcA = 1'b1;
                Output_CU_ALUSrcB = SRCB_REGB;
                Output_CU_ALUOp   = func4_s;
            end
            ST_EXEC_I: begin
                Output_CU_ALUSrcA = 1'b1;
                Output_CU_ALUSrcB = SRCB_IMM;
                // LUI passes the immediate straight through the ALU.
                if (opcode_s == OP_LUI) Output_CU_ALUOp = ALU_PASSB;
                else                    Output_CU_ALUOp = func4_s;
            end
            ST_ALU_WB: begin
                Output_CU_RegWrite = 1'b1;
                Output_CU_MemToReg = 1'b0;
            end
            ST_MEM_ADDR: begin
                Output_CU_ALUSrcA = 1'b1;
                Output_CU_ALUSrcB = SRCB_IMM;
                Output_CU_ALUOp   = ALU_ADD;
            end
            ST_MEM_RD: begin
                Output_CU_MemRead = 1'b1;
                Output_CU_IorD    = 1'b1;
            end
            ST_MEM_WB: begin
                Output_CU_RegWrite = 1'b1;
                Output_CU_MemToReg = 1'b1;
            end
            ST_MEM_WR: begin
                Output_CU_MemWrite = 1'b1;
                Output_CU_IorD     = 1'b1;
            end
            ST_BRANCH: begin
                // func4[0] selects BNE (taken on non-zero) over BEQ.
                Output_CU_ALUSrcA = 1'b1;
                Output_CU_ALUSrcB = SRCB_REGB;
                Output_CU_ALUOp   = ALU_SUB;
                Output_CU_PCSrc   = PCSRC_ALUOUT;
                if (func4_s[0]) Output_CU_PCWrite = ~input_CU_Zero;
                else            Output_CU_PCWrite = input_CU_Zero;
            end
            ST_JUMP: begin
                Output_CU_PCSrc   = PCSRC_IMM;
                Output_CU_PCWrite = 1'b1;
            end
            ST_HALT: Output_CU_Halted = 1'b1;
            ST_ERROR: begin
                Output_CU_Halted = 1'b1;
                Output_CU_Error  = 1'b1;
            end
            default: begin
                Output_CU_Halted = 1'b1;
                Output_CU_Error  = 1'b1;
            end
        endcase
    end

`ifdef CTRL_PERF_CNT_EN
    logic cycle_tick_s;
    logic instr_tick_s;

    assign cycle_tick_s = !((state_r == ST_IDLE) || (state_r == ST_HALT) ||
                            (state_r == ST_ERROR));
    assign instr_tick_s = ((state_next_s == ST_FETCH) && is_completing_state(state_r)) ||
                          ((state_next_s == ST_HALT) && (state_r != ST_HALT));

    // Free-running performance counters; wrap silently.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            Output_CU_CycleCnt <= '0;
            Output_CU_InstrCnt <= '0;
        end else begin
            if (cycle_tick_s) Output_CU_CycleCnt <= Output_CU_CycleCnt + CNT_W'(1);
            else              Output_CU_CycleCnt <= Output_CU_CycleCnt;
            if (instr_tick_s) Output_CU_InstrCnt <= Output_CU_InstrCnt + CNT_W'(1);
            else              Output_CU_InstrCnt <= Output_CU_InstrCnt;
        end
    end
`endif

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_control_unit
// Cycle-by-cycle stimulus rows; each row's expected state and control vector
// is queued when the row is driven and compared mid-cycle.
// ---------------------------------------------------------------------------
module tb_multi_cycle_control_unit;

    localparam int WAIT_MAX = 4;

    logic       CLK;
    logic       RST_n;
    logic [6:0] ctrl;
    logic       zero;
    logic       ready;
    logic       run;
    logic       pcw, irw, mr, mw, iord, rw, m2r, asa, halted, err;
    logic [1:0] asb, pcs;
    logic [3:0] aop, st;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cyc_cnt, ins_cnt;
`endif

    multi_cycle_control_unit #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
        .CLK                (CLK),
        .RST_n              (RST_n),
        .input_CU_Control   (ctrl),
        .input_CU_Zero      (zero),
        .input_CU_MemReady  (ready),
        .input_CU_Run       (run),
        .Output_CU_PCWrite  (pcw),
        .Output_CU_IRWrite  (irw),
        .Output_CU_MemRead  (mr),
        .Output_CU_MemWrite (mw),
        .Output_CU_IorD     (iord),
        .Output_CU_RegWrite (rw),
        .Output_CU_MemToReg (m2r),
        .Output_CU_ALUSrcA  (asa),
        .Output_CU_ALUSrcB  (asb),
        .Output_CU_ALUOp    (aop),
        .Output_CU_PCSrc    (pcs),
        .Output_CU_State    (st),
        .Output_CU_Halted   (halted),
        .Output_CU_Error    (err)
`ifdef CTRL_PERF_CNT_EN
        ,
        .Output_CU_CycleCnt (cyc_cnt),
        .Output_CU_InstrCnt (ins_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Control vector bit positions:
    // {PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, MemToReg, ALUSrcA,
    //  ALUSrcB[1:0], ALUOp[3:0], PCSrc[1:0], Halted, Error}
    localparam logic [17:0] B_PCW  = 18'h20000;
    localparam logic [17:0] B_IRW  = 18'h10000;
    localparam logic [17:0] B_MR   = 18'h08000;
    localparam logic [17:0] B_MW   = 18'h04000;
    localparam logic [17:0] B_IORD = 18'h02000;
    localparam logic [17:0] B_RW   = 18'h01000;
    localparam logic [17:0] B_M2R  = 18'h00800;
    localparam logic [17:0] B_ASA  = 18'h00400;
    localparam logic [17:0] B_H    = 18'h00002;
    localparam logic [17:0] B_E    = 18'h00001;

    function automatic logic [17:0] f_asb(input logic [1:0] v); return {8'd0, v, 8'd0}; endfunction
    function automatic logic [17:0] f_aop(input logic [3:0] v); return {10'd0, v, 4'd0}; endfunction
    function automatic logic [17:0] f_pcs(input logic [1:0] v); return {14'd0, v, 2'd0}; endfunction

    // Expected control vectors per state
    logic [17:0] E_IDLE, E_FW, E_FR, E_NONE, E_AWB, E_MA, E_MRD, E_MWB, E_MWR, E_J, E_ERR;
    initial begin
        E_IDLE = B_H;
        E_FW   = B_MR | f_asb(2'd1);
        E_FR   = B_PCW | B_IRW | B_MR | f_asb(2'd1);
        E_NONE = 18'd0;
        E_AWB  = B_RW;
        E_MA   = B_ASA | f_asb(2'd2);
        E_MRD  = B_MR | B_IORD;
        E_MWB  = B_RW | B_M2R;
        E_MWR  = B_MW | B_IORD;
        E_J    = B_PCW | f_pcs(2'd2);
        E_ERR  = B_H | B_E;
    end
    function automatic logic [17:0] e_r(input logic [3:0] f); return B_ASA | f_aop(f); endfunction
    function automatic logic [17:0] e_i(input logic [3:0] a); return B_ASA | f_asb(2'd2) | f_aop(a); endfunction
    function automatic logic [17:0] e_br(input logic taken);
        return (taken ? B_PCW : 18'd0) | B_ASA | f_aop(4'd1) | f_pcs(2'd1);
    endfunction

    typedef struct packed {
        logic        run;
        logic [6:0]  cin;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] ctl;
    } row_t;

    typedef struct packed {
        logic [3:0]  st;
        logic [17:0] ctl;
    } exp_t;

    row_t rows[$];
    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    function automatic logic [21:0] observed();
        return {st, pcw, irw, mr, mw, iord, rw, m2r, asa, asb, aop, pcs, halted, err};
    endfunction

    function automatic void add(input logic r, input logic [6:0] c, input logic z,
                                input logic rd, input logic [3:0] s, input logic [17:0] e);
        row_t x;
        x.run = r; x.cin = c; x.z = z; x.rdy = rd; x.st = s; x.ctl = e;
        rows.push_back(x);
    endfunction

    // Drive one row's inputs and queue what the DUT should show this cycle.
    task automatic drive(input row_t x);
        exp_t e;
        run = x.run; ctrl = x.cin; zero = x.z; ready = x.rdy;
        e.st = x.st; e.ctl = x.ctl;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        run = 1'b0; ctrl = 7'd0; zero = 1'b0; ready = 1'b0;
        RST_n = 1'b0;
        @(posedge CLK); #1;
        RST_n = 1'b1;
        rows.delete();
    endtask

    task automatic test_reset();
        exp_t e;
        RST_n = 1'b0; run = 1'b0; ctrl = 7'd0; zero = 1'b0; ready = 1'b0;
        rows.delete();
        sb.push_back('{st: 4'd0, ctl: E_IDLE});
        @(negedge CLK);
        e = sb.pop_front();
        checks++;
        if (observed() !== {e.st, e.ctl})
            $display("FAIL reset_asserted: got %h want %h", observed(), {e.st, e.ctl});
        else passed++;
        @(posedge CLK); #1;
        RST_n = 1'b1;
        add(1'b0, 7'd0, 1'b0, 1'b0, 4'd0, E_IDLE);
        add(1'b0, 7'd0, 1'b0, 1'b0, 4'd0, E_IDLE);
        add(1'b1, 7'd0, 1'b0, 1'b0, 4'd0, E_IDLE);
        add(1'b0, 7'd0, 1'b0, 1'b0, 4'd1, E_FW);
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge CLK);
            e = sb.pop_front();
            checks++;
            if (observed() !== {e.st, e.ctl})
                $display("FAIL reset[%0d]: got %h want %h", i, observed(), {e.st, e.ctl});
            else passed++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_rtype_add();
        exp_t e;
        logic [6:0] c;
        c = {4'd0, 3'd0};
        do_reset();
        add(1'b1, c, 1'b0, 1'b0, 4'd0, E_IDLE);
        add(1'b0, c, 1'b0, 1'b0, 4'd1, E_FW);
        add(1'b0, c, 1'b0, 1'b1, 4'd1, E_FR);
        add(1'b0, c, 1'b0, 1'b0, 4'd2, E_NONE);
        add(1'b0, c, 1'b0, 1'b0, 4'd3, E_NONE);
        add(1'b0, c, 1'b0, 1'b0, 4'd4, e_r(4'd0));
        add(1'b0, c, 1'b0, 1'b0, 4'd6, E_AWB);
        add(1'b0, c, 1'b0, 1'b0, 4'd1, E_FW);
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge CLK);
            e = sb.pop_front();
            checks++;
            if (observed() !== {e.st, e.ctl})
                $display("FAIL rtype[%0d]: got %h want %h", i, observed(), {e.st, e.ctl});
            else passed++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_load_delayed();
        exp_t e;
        logic [6:0] c;
        c = {4'd0, 3'd2};
        do_reset();
        add(1'b1, c, 1'b0, 1'b0, 4'd0, E_IDLE);
        add(1'b0, c, 1'b0, 1'b1, 4'd1, E_FR);
        add(1'b0, c, 1'b0, 1'b0, 4'd2, E_NONE);
        add(1'b0, c, 1'b0, 1'b0, 4'd3, E_NONE);
        add(1'b0, c, 1'b0, 1'b0, 4'd7, E_MA);
        add(1'b0, c, 1'b0, 1'b0, 4'd8, E_MRD);
        add(1'b0, c, 1'b0, 1'b0, 4'd8, E_MRD);
        add(1'b0, c, 1'b0, 1'b0, 4'd8, E_MRD);
        add(1'b0, c, 1'b0, 1'b1, 4'd8, E_MRD);   // last allowed wait cycle: ready wins
        add(1'b0, c, 1'b0, 1'b0, 4'd9, E_MWB);
        add(1'b0, c, 1'b0, 1'b0, 4'd1, E_FW);
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge CLK);
            e = sb.pop_front();
            checks++;
            if (observed() !== {e.st, e.ctl})
                $display("FAIL load[%0d]: got %h want %h", i, observed(), {e.st, e.ctl});
            else passed++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_branch();
        exp_t e;
        logic [6:0] beq, bne;
        beq = {4'd0, 3'd4};
        bne = {4'd1, 3'd4};
        do_reset();
        add(1'b1, beq, 1'b1, 1'b0, 4'd0, E_IDLE);
        add(1'b0, beq, 1'b1, 1'b1, 4'd1, E_FR);
        add(1'b0, beq, 1'b1, 1'b0, 4'd2, E_NONE);
        add(1'b0, beq, 1'b1, 1'b0, 4'd3, E_NONE);
        add(1'b0, beq, 1'b1, 1'b0, 4'd11, e_br(1'b1));  // BEQ, Zero=1: taken
        add(1'b0, bne, 1'b1, 1'b1, 4'd1, E_FR);
        add(1'b0, bne, 1'b1, 1'b0, 4'd2, E_NONE);
        add(1'b0, bne, 1'b1, 1'b0, 4'd3, E_NONE);
        add(1'b0, bne, 1'b1, 1'b0, 4'd11, e_br(1'b0));  // BNE, Zero=1: not taken
        add(1'b0, beq, 1'b0, 1'b1, 4'd1, E_FR);
        add(1'b0, beq, 1'b0, 1'b0, 4'd2, E_NONE);
        add(1'b0, beq, 1'b0, 1'b0, 4'd3, E_NONE);
        add(1'b0, beq, 1'b0, 1'b0, 4'd11, e_br(1'b0));  // BEQ, Zero=0: not taken
        add(1'b0, bne, 1'b0, 1'b1, 4'd1, E_FR);
        add(1'b0, bne, 1'b0, 1'b0, 4'd2, E_NONE);
        add(1'b0, bne, 1'b0, 1'b0, 4'd3, E_NONE);
        add(1'b0, bne, 1'b0, 1'b0, 4'd11, e_br(1'b1));  // BNE, Zero=0: taken
        add(1'b0, bne, 1'b0, 1'b0, 4'd1, E_FW);
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge CLK);
            e = sb.pop_front();
            checks++;
            if (observed() !== {e.st, e.ctl})
                $display("FAIL branch[%0d]: got %h want %h", i, observed(), {e.st, e.ctl});
            else passed++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_jump_imm();
        exp_t e;
        do_reset();
        add(1'b1, {4'd0, 3'd5}, 1'b0, 1'b0, 4'd0, E_IDLE);
        add(1'b0, {4'd0, 3'd5}, 1'b0, 1'b1, 4'd1, E_FR);
        add(1'b0, {4'd0, 3'd5}, 1'b0, 1'b0, 4'd2, E_NONE);
        add(1'b0, {4'd0, 3'd5}, 1'b0, 1'b0, 4'd3, E_NONE);
        add(1'b0, {4'd0, 3'd5}, 1'b0, 1'b0, 4'd12, E_J);
        add(1'b0, {4'd3, 3'd6}, 1'b0, 1'b1, 4'd1, E_FR);
        add(1'b0, {4'd3, 3'd6}, 1'b0, 1'b0, 4'd2, E_NONE);
        add(1'b0, {4'd3, 3'd6}, 1'b0, 1'b0, 4'd3, E_NONE);
        add(1'b0, {4'd3, 3'd6}, 1'b0, 1'b0, 4'd5, e_i(4'd15));  // LUI: PASSB
        add(1'b0, {4'd3, 3'd6}, 1'b0, 1'b0, 4'd6, E_AWB);
        add(1'b0, {4'd0, 3'd1}, 1'b0, 1'b1, 4'd1, E_FR);
        add(1'b0, {4'd0, 3'd1}, 1'b0, 1'b0, 4'd2, E_NONE);
        add(1'b0, {4'd0, 3'd1}, 1'b0, 1'b0, 4'd3, E_NONE);
        add(1'b0, {4'd0, 3'd1}, 1'b0, 1'b0, 4'd5, e_i(4'd0));
        add(1'b0, {4'd0, 3'd1}, 1'b0, 1'b0, 4'd6, E_AWB);
        add(1'b0, {4'd0, 3'd1}, 1'b0, 1'b0, 4'd1, E_FW);
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge CLK);
            e = sb.pop_front();
            checks++;
            if (observed() !== {e.st, e.ctl})
                $display("FAIL jump_imm[%0d]: got %h want %h", i, observed(), {e.st, e.ctl});
            else passed++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_halt();
        exp_t e;
        logic [6:0] c;
        c = {4'd0, 3'd7};
        do_reset();
        add(1'b1, c, 1'b0, 1'b0, 4'd0, E_IDLE);
        add(1'b0, c, 1'b0, 1'b1, 4'd1, E_FR);
        add(1'b0, c, 1'b0, 1'b0, 4'd2, E_NONE);
        add(1'b0, c, 1'b0, 1'b0, 4'd3, E_NONE);
        add(1'b0, c, 1'b0, 1'b0, 4'd13, E_IDLE);
        add(1'b0, c, 1'b0, 1'b0, 4'd13, E_IDLE);
        add(1'b1, c, 1'b0, 1'b0, 4'd13, E_IDLE);
        add(1'b0, c, 1'b0, 1'b0, 4'd1, E_FW);
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge CLK);
            e = sb.pop_front();
            checks++;
            if (observed() !== {e.st, e.ctl})
                $display("FAIL halt[%0d]: got %h want %h", i, observed(), {e.st, e.ctl});
            else passed++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_fetch_timeout();
        exp_t e;
        do_reset();
        add(1'b1, 7'd0, 1'b0, 1'b0, 4'd0, E_IDLE);
        for (int k = 0; k < WAIT_MAX; k++) add(1'b0, 7'd0, 1'b0, 1'b0, 4'd1, E_FW);
        add(1'b1, 7'd0, 1'b0, 1'b0, 4'd14, E_ERR);
        add(1'b1, 7'd0, 1'b0, 1'b1, 4'd14, E_ERR);
        add(1'b0, 7'd0, 1'b0, 1'b0, 4'd14, E_ERR);
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge CLK);
            e = sb.pop_front();
            checks++;
            if (observed() !== {e.st, e.ctl})
                $display("FAIL timeout[%0d]: got %h want %h", i, observed(), {e.st, e.ctl});
            else passed++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        do_reset();
        add(1'b1, {4'd9, 3'd0}, 1'b0, 1'b0, 4'd0, E_IDLE);
        add(1'b0, {4'd9, 3'd0}, 1'b0, 1'b1, 4'd1, E_FR);
        add(1'b0, {4'd9, 3'd0}, 1'b0, 1'b0, 4'd2, E_NONE);
        add(1'b0, {4'd9, 3'd0}, 1'b0, 1'b0, 4'd3, E_NONE);
        add(1'b0, {4'd9, 3'd0}, 1'b0, 1'b0, 4'd4, e_r(4'd9));
        add(1'b0, {4'd9, 3'd0}, 1'b0, 1'b0, 4'd6, E_AWB);
        add(1'b0, {4'd0, 3'd3}, 1'b0, 1'b1, 4'd1, E_FR);
        add(1'b0, {4'd0, 3'd3}, 1'b0, 1'b0, 4'd2, E_NONE);
        add(1'b0, {4'd0, 3'd3}, 1'b0, 1'b0, 4'd3, E_NONE);
        add(1'b0, {4'd0, 3'd3}, 1'b0, 1'b0, 4'd7, E_MA);
        add(1'b0, {4'd0, 3'd3}, 1'b0, 1'b0, 4'd10, E_MWR);
        add(1'b0, {4'd0, 3'd3}, 1'b0, 1'b1, 4'd10, E_MWR);
        add(1'b0, {4'd0, 3'd2}, 1'b0, 1'b1, 4'd1, E_FR);
        add(1'b0, {4'd0, 3'd2}, 1'b0, 1'b0, 4'd2, E_NONE);
        add(1'b0, {4'd0, 3'd2}, 1'b0, 1'b0, 4'd3, E_NONE);
        add(1'b0, {4'd0, 3'd2}, 1'b0, 1'b0, 4'd7, E_MA);
        add(1'b0, {4'd0, 3'd2}, 1'b0, 1'b1, 4'd8, E_MRD);
        add(1'b0, {4'd0, 3'd2}, 1'b0, 1'b0, 4'd9, E_MWB);
        add(1'b0, {4'd0, 3'd2}, 1'b0, 1'b0, 4'd1, E_FW);
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge CLK);
            e = sb.pop_front();
            checks++;
            if (observed() !== {e.st, e.ctl})
                $display("FAIL back_to_back[%0d]: got %h want %h", i, observed(), {e.st, e.ctl});
            else passed++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset_mid_write();
        exp_t e;
        logic [6:0] c;
        c = {4'd0, 3'd3};
        do_reset();
        add(1'b1, c, 1'b0, 1'b0, 4'd0, E_IDLE);
        add(1'b0, c, 1'b0, 1'b1, 4'd1, E_FR);
        add(1'b0, c, 1'b0, 1'b0, 4'd2, E_NONE);
        add(1'b0, c, 1'b0, 1'b0, 4'd3, E_NONE);
        add(1'b0, c, 1'b0, 1'b0, 4'd7, E_MA);
        add(1'b0, c, 1'b0, 1'b0, 4'd10, E_MWR);
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge CLK);
            e = sb.pop_front();
            checks++;
            if (observed() !== {e.st, e.ctl})
                $display("FAIL mid_write[%0d]: got %h want %h", i, observed(), {e.st, e.ctl});
            else passed++;
            @(posedge CLK); #1;
        end
        // Still in MEM_WR; pull reset between edges and look before any edge.
        sb.push_back('{st: 4'd0, ctl: E_IDLE});
        RST_n = 1'b0;
        #1;
        e = sb.pop_front();
        checks++;
        if (observed() !== {e.st, e.ctl} || mw !== 1'b0)
            $display("FAIL reset_mid_write: got %h memwrite %b want %h memwrite 0",
                     observed(), mw, {e.st, e.ctl});
        else passed++;
        @(posedge CLK); #1;
        RST_n = 1'b1;
    endtask

    initial begin
        RST_n = 1'b0; run = 1'b0; ctrl = 7'd0; zero = 1'b0; ready = 1'b0;
        test_reset();
        test_rtype_add();
        test_load_delayed();
        test_branch();
        test_jump_imm();
        test_halt();
        test_fetch_timeout();
        test_back_to_back();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
